// File: rtl/rr_arb_mux_to_receiver.sv
// Round-robin arbiter + mux forwarding one of SENDER_NUM valid/ready streams to receiver RECEIVER_CHOSEN.
// Define RR_ARB_BURST_LOCK_EN to hold the grant until a handshake with last asserted.
module rr_arb_mux_to_receiver #(
  parameter int WIDTH           = 1,
  parameter int SENDER_NUM      = 8,
  parameter int RECEIVER_NUM    = 8,
  parameter int RECEIVER_CHOSEN = 1
) (
  input  logic                    ACLK,
  input  logic                    ARESETn,
  input  logic [WIDTH-1:0]        signal    [SENDER_NUM],
  input  logic [RECEIVER_NUM-1:0] select    [SENDER_NUM],
  input  logic [SENDER_NUM-1:0]   valid_in,
  input  logic [SENDER_NUM-1:0]   last_in,
  output logic [SENDER_NUM-1:0]   ready_out,
  output logic [WIDTH-1:0]        val_sig,
  output logic                    valid_out,
  output logic                    last_out,
  input  logic                    ready_in,
  output logic [SENDER_NUM-1:0]   grant
);

  localparam int PTR_W = (SENDER_NUM > 1) ? $clog2(SENDER_NUM) : 1;
  localparam int unsigned N = SENDER_NUM;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t                state;
  logic [PTR_W-1:0]      rr_ptr;
  logic [PTR_W-1:0]      grant_idx;
  logic [SENDER_NUM-1:0] req;
  logic [SENDER_NUM-1:0] unused_sel;
  logic                  pick_found;
  logic [PTR_W-1:0]      pick_idx;
  logic [PTR_W-1:0]      cand_idx;
  logic [SENDER_NUM-1:0] pick_onehot;
  int unsigned           cand;
  logic                  busy;
  logic                  handshake;
  logic                  release_hs;

  always_comb begin
    for (int unsigned i = 0; i < N; i++) begin
      req[i]        = valid_in[i] & select[i][RECEIVER_CHOSEN];
      unused_sel[i] = ^select[i];
    end
  end

  // Scan from rr_ptr upward with wrap; the first requester found wins.
  always_comb begin
    pick_found  = 1'b0;
    pick_idx    = '0;
    cand        = 0;
    cand_idx    = '0;
    pick_onehot = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = 32'(rr_ptr) + k;
      if (cand >= N) cand = cand - N;
      cand_idx = PTR_W'(cand);
      if (!pick_found && req[cand_idx]) begin
        pick_found = 1'b1;
        pick_idx   = cand_idx;
      end
    end
    if (pick_found) pick_onehot[pick_idx] = 1'b1;
  end

  always_comb begin
    busy      = (state == BUSY);
    val_sig   = busy ? signal[grant_idx] : '0;
    valid_out = busy & valid_in[grant_idx];
    last_out  = busy & last_in[grant_idx];
    ready_out = busy ? (grant & {SENDER_NUM{ready_in}}) : '0;
    handshake = valid_out & ready_in;
`ifdef RR_ARB_BURST_LOCK_EN
    release_hs = handshake & last_out;
`else
    release_hs = handshake;
`endif
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state     <= IDLE;
      grant     <= '0;
      grant_idx <= '0;
      rr_ptr    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            state     <= BUSY;
            grant     <= pick_onehot;
            grant_idx <= pick_idx;
          end
        end
        BUSY: begin
          if (release_hs) begin
            state  <= IDLE;
            grant  <= '0;
            rr_ptr <= (grant_idx == PTR_W'(SENDER_NUM - 1)) ? '0 : grant_idx + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arb_mux_to_receiver.sv
// Directed self-checking bench for rr_arb_mux_to_receiver (default parameters, receiver 1).
// Burst expectations follow RR_ARB_BURST_LOCK_EN when it is defined for the build.
module tb_rr_arb_mux_to_receiver;

  logic       ACLK = 1'b0;
  logic       ARESETn;
  logic [0:0] signal [8];
  logic [7:0] select [8];
  logic [7:0] valid_in;
  logic [7:0] last_in;
  logic [7:0] ready_out;
  logic [0:0] val_sig;
  logic       valid_out;
  logic       last_out;
  logic       ready_in;
  logic [7:0] grant;

  int checks = 0;
  int errors = 0;

  always #5 ACLK = ~ACLK;

  rr_arb_mux_to_receiver #(
    .WIDTH(1), .SENDER_NUM(8), .RECEIVER_NUM(8), .RECEIVER_CHOSEN(1)
  ) dut (
    .ACLK(ACLK), .ARESETn(ARESETn), .signal(signal), .select(select),
    .valid_in(valid_in), .last_in(last_in), .ready_out(ready_out),
    .val_sig(val_sig), .valid_out(valid_out), .last_out(last_out),
    .ready_in(ready_in), .grant(grant)
  );

  // Advance to just after the next rising edge; inputs are driven here, checks follow a #1.
  task automatic cyc();
    @(posedge ACLK);
    #1;
  endtask

  task automatic clear_inputs();
    valid_in = '0;
    last_in  = '0;
    ready_in = 1'b0;
    for (int i = 0; i < 8; i++) begin
      signal[i] = '0;
      select[i] = 8'h02;
    end
  endtask

  task automatic do_reset();
    ARESETn = 1'b0;
    clear_inputs();
    cyc();
    ARESETn = 1'b1;
  endtask

  task automatic test_reset();
    ARESETn = 1'b0;
    clear_inputs();
    valid_in = 8'hFF;
    last_in  = 8'hFF;
    ready_in = 1'b1;
    cyc();
    cyc();
    #1;
    checks++;
    if (grant !== 8'h00) begin errors++; $display("FAIL reset_grant got %h want %h", grant, 8'h00); end
    checks++;
    if ({valid_out, last_out, val_sig} !== 3'b000) begin
      errors++; $display("FAIL reset_outs got %b want %b", {valid_out, last_out, val_sig}, 3'b000);
    end
    checks++;
    if (ready_out !== 8'h00) begin errors++; $display("FAIL reset_ready got %h want %h", ready_out, 8'h00); end
    // Release reset with everyone requesting: sender 0 must win first.
    ARESETn  = 1'b1;
    ready_in = 1'b0;
    cyc();
    #1;
    checks++;
    if (grant !== 8'h01) begin errors++; $display("FAIL reset_first_grant got %h want %h", grant, 8'h01); end
    do_reset();
  endtask

  task automatic test_single();
    valid_in  = 8'h04;
    last_in   = 8'h04;
    signal[2] = 1'b1;
    ready_in  = 1'b1;
    #1;
    checks++;
    if (grant !== 8'h00 || valid_out !== 1'b0) begin
      errors++; $display("FAIL single_bubble got grant %h valid %b want 00 0", grant, valid_out);
    end
    cyc();
    #1;
    checks++;
    if (grant !== 8'h04) begin errors++; $display("FAIL single_grant got %h want %h", grant, 8'h04); end
    checks++;
    if ({val_sig, valid_out, last_out} !== 3'b111) begin
      errors++; $display("FAIL single_data got %b want %b", {val_sig, valid_out, last_out}, 3'b111);
    end
    checks++;
    if (ready_out !== 8'h04) begin errors++; $display("FAIL single_ready got %h want %h", ready_out, 8'h04); end
    cyc();
    // Handshake done; pointer now 3, so with 2 and 3 requesting, 3 goes first.
    valid_in = 8'h0C;
    last_in  = 8'hFF;
    #1;
    checks++;
    if (grant !== 8'h00 || valid_out !== 1'b0 || val_sig !== 1'b0) begin
      errors++; $display("FAIL single_idle got grant %h valid %b sig %b want 00 0 0", grant, valid_out, val_sig);
    end
    cyc();
    #1;
    checks++;
    if (grant !== 8'h08) begin errors++; $display("FAIL ptr3_grant got %h want %h", grant, 8'h08); end
    cyc();
    valid_in = 8'h04;
    cyc();
    #1;
    checks++;
    if (grant !== 8'h04) begin errors++; $display("FAIL ptr4_wrap_grant got %h want %h", grant, 8'h04); end
    cyc();
    valid_in = 8'h00;
    signal[2] = 1'b0;
  endtask

  task automatic test_fairness();
    logic [7:0] exp_g [8];
    exp_g = '{8'h01, 8'h00, 8'h08, 8'h00, 8'h80, 8'h00, 8'h01, 8'h00};
    do_reset();
    valid_in = 8'h89;
    last_in  = 8'hFF;
    ready_in = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cyc();
      #1;
      checks++;
      if (grant !== exp_g[i] || valid_out !== (exp_g[i] != 8'h00)) begin
        errors++;
        $display("FAIL fair_step%0d got grant %h valid %b want %h %b", i, grant, valid_out, exp_g[i], exp_g[i] != 8'h00);
      end
    end
    clear_inputs();
  endtask

  task automatic test_wrap();
    logic [7:0] exp_g [5];
    exp_g = '{8'h80, 8'h00, 8'h02, 8'h00, 8'h80};
    do_reset();
    valid_in = 8'h40;
    last_in  = 8'hFF;
    ready_in = 1'b1;
    cyc();
    #1;
    checks++;
    if (grant !== 8'h40) begin errors++; $display("FAIL wrap_setup got %h want %h", grant, 8'h40); end
    cyc();
    valid_in = 8'h82;
    for (int i = 0; i < 5; i++) begin
      cyc();
      #1;
      checks++;
      if (grant !== exp_g[i]) begin
        errors++; $display("FAIL wrap_step%0d got %h want %h", i, grant, exp_g[i]);
      end
    end
    clear_inputs();
  endtask

  task automatic test_burst();
    do_reset();
    valid_in  = 8'h30;
    last_in   = 8'h20;
    signal[4] = 1'b1;
    ready_in  = 1'b1;
    cyc();
    #1;
    checks++;
    if (grant !== 8'h10 || last_out !== 1'b0 || val_sig !== 1'b1) begin
      errors++; $display("FAIL burst_beat1 got grant %h last %b sig %b want 10 0 1", grant, last_out, val_sig);
    end
    cyc();
`ifdef RR_ARB_BURST_LOCK_EN
    signal[4] = 1'b0;
    #1;
    checks++;
    if (grant !== 8'h10 || val_sig !== 1'b0 || last_out !== 1'b0) begin
      errors++; $display("FAIL burst_beat2 got grant %h sig %b last %b want 10 0 0", grant, val_sig, last_out);
    end
    cyc();
    last_in = 8'h30;
    #1;
    checks++;
    if (grant !== 8'h10 || last_out !== 1'b1) begin
      errors++; $display("FAIL burst_beat3 got grant %h last %b want 10 1", grant, last_out);
    end
    cyc();
    valid_in = 8'h20;
    #1;
    checks++;
    if (grant !== 8'h00) begin errors++; $display("FAIL burst_release got %h want %h", grant, 8'h00); end
    cyc();
    #1;
    checks++;
    if (grant !== 8'h20) begin errors++; $display("FAIL burst_next got %h want %h", grant, 8'h20); end
`else
    #1;
    checks++;
    if (grant !== 8'h00) begin errors++; $display("FAIL burst_release got %h want %h", grant, 8'h00); end
    cyc();
    #1;
    checks++;
    if (grant !== 8'h20) begin errors++; $display("FAIL burst_next got %h want %h", grant, 8'h20); end
`endif
    clear_inputs();
  endtask

  task automatic test_filter_backpressure();
    do_reset();
    select[1] = 8'h01;
    valid_in  = 8'h02;
    last_in   = 8'hFF;
    signal[1] = 1'b1;
    ready_in  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      #1;
      checks++;
      if (grant !== 8'h00 || valid_out !== 1'b0) begin
        errors++; $display("FAIL filter_%0d got grant %h valid %b want 00 0", i, grant, valid_out);
      end
    end
    select[1] = 8'h02;
    ready_in  = 1'b0;
    cyc();
    valid_in = 8'h06;
    for (int i = 0; i < 5; i++) begin
      cyc();
      #1;
      checks++;
      if (grant !== 8'h02 || val_sig !== 1'b1 || valid_out !== 1'b1 || ready_out !== 8'h00) begin
        errors++;
        $display("FAIL stall_%0d got grant %h sig %b valid %b rdy %h want 02 1 1 00", i, grant, val_sig, valid_out, ready_out);
      end
    end
    // Granted sender drops valid and its select changes: grant must hold, no re-arbitration.
    valid_in  = 8'h04;
    select[1] = 8'h01;
    ready_in  = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cyc();
      #1;
      checks++;
      if (grant !== 8'h02 || valid_out !== 1'b0 || ready_out !== 8'h02) begin
        errors++;
        $display("FAIL drop_%0d got grant %h valid %b rdy %h want 02 0 02", i, grant, valid_out, ready_out);
      end
    end
    valid_in = 8'h06;
    cyc();
    valid_in = 8'h04;
    #1;
    checks++;
    if (grant !== 8'h00) begin errors++; $display("FAIL stall_release got %h want %h", grant, 8'h00); end
    cyc();
    #1;
    checks++;
    if (grant !== 8'h04) begin errors++; $display("FAIL stall_next got %h want %h", grant, 8'h04); end
    clear_inputs();
  endtask

  task automatic test_reset_midburst();
    do_reset();
    valid_in = 8'h20;
    last_in  = 8'hFF;
    ready_in = 1'b1;
    cyc();
    cyc();
    valid_in = 8'h40;
    ready_in = 1'b0;
    cyc();
    cyc();
    #1;
    checks++;
    if (grant !== 8'h40) begin errors++; $display("FAIL midrst_setup got %h want %h", grant, 8'h40); end
    ARESETn  = 1'b0;
    ready_in = 1'b1;
    cyc();
    #1;
    checks++;
    if (grant !== 8'h00 || valid_out !== 1'b0 || ready_out !== 8'h00) begin
      errors++; $display("FAIL midrst_outs got grant %h valid %b rdy %h want 00 0 00", grant, valid_out, ready_out);
    end
    // Pointer was 6 before reset; sender 0 winning over 6 shows it returned to 0.
    ARESETn  = 1'b1;
    valid_in = 8'h41;
    ready_in = 1'b0;
    cyc();
    #1;
    checks++;
    if (grant !== 8'h01) begin errors++; $display("FAIL midrst_ptr got %h want %h", grant, 8'h01); end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_wrap();
    test_burst();
    test_filter_backpressure();
    test_reset_midburst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
